// File: rtl/cplx_pwr.sv
// Pipelined complex magnitude-squared: stage 1 registers I^2 and Q^2, stage 2 registers their sum.
// Full precision throughout; the most negative input squared twice still fits 2*IN_W unsigned bits.
module cplx_pwr #(
  parameter int IN_W = 28,
  localparam int PWR_W = 2*IN_W
) (
  input  logic                    mclk,
  input  logic                    init,
  input  logic                    vld,
  input  logic signed [IN_W-1:0]  i,
  input  logic signed [IN_W-1:0]  q,
  output logic                    pwr_vld,
  output logic [PWR_W-1:0]        pwr
);
  logic [1:0]              vld_pipe;
  logic signed [PWR_W-1:0] ii, qq;
  logic [PWR_W-1:0]        sq_i, sq_q;

  assign ii = PWR_W'(i) * PWR_W'(i);
  assign qq = PWR_W'(q) * PWR_W'(q);

  always_ff @(posedge mclk) begin
    if (init) begin
      vld_pipe <= '0;
      sq_i     <= '0;
      sq_q     <= '0;
      pwr      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], vld};
      sq_i     <= $unsigned(ii);
      sq_q     <= $unsigned(qq);
      pwr      <= sq_i + sq_q;
    end
  end

  assign pwr_vld = vld_pipe[1];
endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame FFT bin power, peak bin, total energy and clip flag.
// Input-side FSM frames the bins; per-sample tags ride alongside the power pipeline.
module fft_peak_detect #(
  parameter int IN_W    = 28,
  parameter int FFT_LEN = 256,
  localparam int STAGES = $clog2(FFT_LEN),
  localparam int PWR_W  = 2*IN_W,
  localparam int EN_W   = PWR_W + STAGES
) (
  input  logic                   mclk,
  input  logic                   i_init,
  input  logic                   i_vld,
  input  logic                   i_new_fft,
  input  logic signed [IN_W-1:0] i_I,
  input  logic signed [IN_W-1:0] i_Q,
  input  logic                   i_clip_strb,
  output logic                   o_pwr_vld,
  output logic [PWR_W-1:0]       o_pwr,
  output logic                   o_res_vld,
  output logic [STAGES-1:0]      o_peak_bin,
  output logic [PWR_W-1:0]       o_peak_pwr,
  output logic [EN_W-1:0]        o_energy,
  output logic                   o_clipped,
  output logic                   o_frame_err
);
  localparam logic [STAGES:0] CNT_FULL = (STAGES+1)'(FFT_LEN);
  localparam logic [STAGES:0] CNT_ONE  = (STAGES+1)'(1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, nxt_state;

  logic [STAGES:0]   cnt, nxt_cnt;
  logic              acc, first, last, err, clip_acc, clip_tag;
  logic [STAGES-1:0] bin;

  // cnt = bins accepted in the current frame; CNT_FULL means waiting for the next bin 0
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    acc       = 1'b0;
    first     = 1'b0;
    err       = 1'b0;
    if (i_vld) begin
      if (i_new_fft) begin
        acc       = 1'b1;
        first     = 1'b1;
        nxt_state = RUN;
        nxt_cnt   = CNT_ONE;
        err       = (state == RUN) && (cnt != CNT_FULL);
      end else if (state == RUN) begin
        if (cnt == CNT_FULL) begin
          err       = 1'b1;
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else begin
          acc     = 1'b1;
          nxt_cnt = cnt + 1'b1;
        end
      end
    end
  end

  assign last     = acc && (nxt_cnt == CNT_FULL);
  assign bin      = first ? '0 : cnt[STAGES-1:0];
  assign clip_tag = (!first && clip_acc) || i_clip_strb;

  always_ff @(posedge mclk) begin
    if (i_init) begin
      state       <= IDLE;
      cnt         <= '0;
      clip_acc    <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      o_frame_err <= err;
      if (acc)
        clip_acc <= clip_tag;
      else if (state == RUN && cnt != CNT_FULL)
        clip_acc <= clip_acc | i_clip_strb;
    end
  end

  // Tags aligned with the two power stages
  logic [1:0]              first_p, last_p, clip_p;
  logic [1:0][STAGES-1:0]  bin_p;

  always_ff @(posedge mclk) begin
    if (i_init) begin
      first_p <= '0;
      last_p  <= '0;
      clip_p  <= '0;
      bin_p   <= '0;
    end else begin
      first_p <= {first_p[0], first};
      last_p  <= {last_p[0], last};
      clip_p  <= {clip_p[0], clip_tag};
      bin_p   <= {bin_p[0], bin};
    end
  end

  cplx_pwr #(.IN_W(IN_W)) u_pwr (
    .mclk    (mclk),
    .init    (i_init),
    .vld     (acc),
    .i       (i_I),
    .q       (i_Q),
    .pwr_vld (o_pwr_vld),
    .pwr     (o_pwr)
  );

  logic [PWR_W-1:0]  pk_pwr, fin_pwr;
  logic [STAGES-1:0] pk_bin, fin_bin;
  logic [EN_W-1:0]   en, fin_en;

  // Strict greater-than keeps the lowest bin on ties; bin 0 reseeds every frame
  always_comb begin
    fin_pwr = pk_pwr;
    fin_bin = pk_bin;
    fin_en  = en + EN_W'(o_pwr);
    if (first_p[1]) begin
      fin_pwr = o_pwr;
      fin_bin = '0;
      fin_en  = EN_W'(o_pwr);
    end else if (o_pwr > pk_pwr) begin
      fin_pwr = o_pwr;
      fin_bin = bin_p[1];
    end
  end

  always_ff @(posedge mclk) begin
    if (i_init) begin
      pk_pwr     <= '0;
      pk_bin     <= '0;
      en         <= '0;
      o_res_vld  <= 1'b0;
      o_peak_bin <= '0;
      o_peak_pwr <= '0;
      o_energy   <= '0;
      o_clipped  <= 1'b0;
    end else begin
      o_res_vld <= o_pwr_vld && last_p[1];
      if (o_pwr_vld) begin
        pk_pwr <= fin_pwr;
        pk_bin <= fin_bin;
        en     <= fin_en;
      end
      if (o_pwr_vld && last_p[1]) begin
        o_peak_bin <= fin_bin;
        o_peak_pwr <= fin_pwr;
        o_energy   <= fin_en;
        o_clipped  <= clip_p[1];
      end
    end
  end
endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect at FFT_LEN=8, IN_W=4.
module tb_fft_peak_detect;
  localparam int IN_W = 4, FFT_LEN = 8, STAGES = 3, PWR_W = 8, EN_W = 11;

  logic                   mclk = 1'b0;
  logic                   i_init, i_vld, i_new_fft, i_clip_strb;
  logic signed [IN_W-1:0] i_I, i_Q;
  logic                   o_pwr_vld, o_res_vld, o_clipped, o_frame_err;
  logic [PWR_W-1:0]       o_pwr, o_peak_pwr;
  logic [STAGES-1:0]      o_peak_bin;
  logic [EN_W-1:0]        o_energy;

  fft_peak_detect #(.IN_W(IN_W), .FFT_LEN(FFT_LEN)) dut (
    .mclk(mclk), .i_init(i_init), .i_vld(i_vld), .i_new_fft(i_new_fft),
    .i_I(i_I), .i_Q(i_Q), .i_clip_strb(i_clip_strb),
    .o_pwr_vld(o_pwr_vld), .o_pwr(o_pwr), .o_res_vld(o_res_vld),
    .o_peak_bin(o_peak_bin), .o_peak_pwr(o_peak_pwr), .o_energy(o_energy),
    .o_clipped(o_clipped), .o_frame_err(o_frame_err)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  typedef struct {int bin; int pk; int en; int clip; int at;} res_t;
  int   pwr_q[$], pwr_at[$], err_at[$];
  res_t res_q[$];
  int   fi[FFT_LEN], fq[FFT_LEN];
  int   last_c;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output
  always @(negedge mclk) begin
    res_t r;
    if (o_pwr_vld) begin
      if (pwr_q.size() == 0) chk("pwr_unexpected", o_pwr_vld, 0);
      else begin
        chk("pwr_value", o_pwr, pwr_q.pop_front());
        chk("pwr_latency", cyc, pwr_at.pop_front());
      end
    end
    if (o_res_vld) begin
      if (res_q.size() == 0) chk("res_unexpected", o_res_vld, 0);
      else begin
        r = res_q.pop_front();
        chk("res_peak_bin", o_peak_bin, r.bin);
        chk("res_peak_pwr", o_peak_pwr, r.pk);
        chk("res_energy", o_energy, r.en);
        chk("res_clipped", o_clipped, r.clip);
        chk("res_latency", cyc, r.at);
      end
    end
    if (o_frame_err) begin
      if (err_at.size() == 0) chk("frame_err_unexpected", o_frame_err, 0);
      else chk("frame_err_cycle", cyc, err_at.pop_front());
    end
  end

  task automatic idle();
    @(negedge mclk);
    i_vld = 0; i_new_fft = 0; i_clip_strb = 0; i_I = '0; i_Q = '0;
  endtask

  task automatic send(input bit nf, input int vi, input int vq, input bit clip, input bit exp_pwr);
    @(negedge mclk);
    i_vld = 1; i_new_fft = nf; i_I = IN_W'(vi); i_Q = IN_W'(vq); i_clip_strb = clip;
    last_c = cyc;
    if (exp_pwr) begin
      pwr_q.push_back(vi*vi + vq*vq);
      pwr_at.push_back(cyc + 2);
    end
  endtask

  task automatic run_frame(input bit bubbles, input bit exp_err, input int clip_bin,
                           input int eb, input int ep, input int ee, input int ec);
    for (int b = 0; b < FFT_LEN; b++) begin
      send(b == 0, fi[b], fq[b], b == clip_bin, 1'b1);
      if (b == 0 && exp_err) err_at.push_back(last_c + 1);
      if (bubbles && b != FFT_LEN-1) idle();
    end
    res_q.push_back('{eb, ep, ee, ec, last_c + 3});
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_pwr_vld"}, o_pwr_vld, 0);
    chk({tag, "_pwr"}, o_pwr, 0);
    chk({tag, "_res_vld"}, o_res_vld, 0);
    chk({tag, "_peak_bin"}, o_peak_bin, 0);
    chk({tag, "_peak_pwr"}, o_peak_pwr, 0);
    chk({tag, "_energy"}, o_energy, 0);
    chk({tag, "_clipped"}, o_clipped, 0);
    chk({tag, "_frame_err"}, o_frame_err, 0);
  endtask

  task automatic load_single();
    for (int b = 0; b < FFT_LEN; b++) begin fi[b] = 0; fq[b] = 0; end
    fi[5] = 7;
  endtask

  task automatic load_tie();
    for (int b = 0; b < FFT_LEN; b++) begin fi[b] = 0; fq[b] = 0; end
    fi[2] = 3; fq[2] = -4; fi[6] = 3; fq[6] = -4;
  endtask

  initial begin
    i_init = 1; i_vld = 0; i_new_fft = 0; i_I = '0; i_Q = '0; i_clip_strb = 0;
    repeat (3) @(negedge mclk);
    check_zero("reset");
    i_init = 0;
    idle();

    // Single peak at bin 5
    load_single();
    run_frame(0, 0, -1, 5, 49, 49, 0);
    repeat (6) idle();
    chk("hold_peak_bin", o_peak_bin, 5);
    chk("hold_peak_pwr", o_peak_pwr, 49);

    // Tie frame, then an all-(-8,-8) frame back to back
    load_tie();
    run_frame(0, 0, -1, 2, 25, 50, 0);
    for (int b = 0; b < FFT_LEN; b++) begin fi[b] = -8; fq[b] = -8; end
    run_frame(0, 0, -1, 0, 128, 1024, 0);
    repeat (3) idle();

    // Short frame of 5 bins aborted by a new bin 0
    for (int b = 0; b < 5; b++) send(b == 0, 1, 1, 0, 1'b1);
    load_single();
    run_frame(0, 1, -1, 5, 49, 49, 0);
    repeat (3) idle();

    // Bubbles every other cycle, clip at bin 3
    run_frame(1, 0, 3, 5, 49, 49, 1);
    repeat (3) idle();

    // Sample after the last bin without i_new_fft, then a stray sample in IDLE
    send(0, 2, 2, 0, 1'b0);
    err_at.push_back(last_c + 1);
    idle();
    send(0, 2, 2, 0, 1'b0);
    idle();
    load_tie();
    run_frame(0, 0, -1, 2, 25, 50, 0);
    repeat (3) idle();

    // i_init at bin 4: bins 0..2 already past stage 2, bin 3 in flight is dropped
    for (int b = 0; b < 4; b++) send(b == 0, 1, 2, 0, b < 3);
    send(0, 1, 2, 0, 1'b0);
    i_init = 1;
    @(negedge mclk);
    check_zero("init");
    i_init = 0; i_vld = 0; i_new_fft = 0;
    idle();
    load_single();
    run_frame(0, 0, -1, 5, 49, 49, 0);
    repeat (10) idle();

    chk("pwr_missing", pwr_q.size(), 0);
    chk("res_missing", res_q.size(), 0);
    chk("frame_err_missing", err_at.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter IN_W, default 28, meaning signed bin width; matches the FFT output width.
REQ-002 SHALL have parameter FFT_LEN, default 256, meaning bins per frame; power of two, >= 4.
REQ-003 SHALL derive localparams STAGES = $clog2(FFT_LEN), PWR_W = 2*IN_W and EN_W = PWR_W+STAGES.
REQ-004 SHALL have port mclk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port i_init, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port i_vld, input, 1 bit: bin sample valid.
REQ-007 SHALL have port i_new_fft, input, 1 bit: qualified by i_vld, marks bin 0 of a frame.
REQ-008 SHALL have ports i_I and i_Q, inputs, signed IN_W each: bin real and imaginary parts.
REQ-009 SHALL have port i_clip_strb, input, 1 bit: upstream clip indication, sampled every cycle.
REQ-010 SHALL have port o_pwr_vld, output, 1 bit: per-bin power valid.
REQ-011 SHALL have port o_pwr, output, unsigned PWR_W: I^2+Q^2 of the bin.
REQ-012 SHALL have port o_res_vld, output, 1 bit: one-cycle frame-result strobe.
REQ-013 SHALL have ports o_peak_bin (STAGES), o_peak_pwr (PWR_W) and o_energy (EN_W), all outputs, holding the frame results.
REQ-014 SHALL have port o_clipped, output, 1 bit: clip seen during the reported frame.
REQ-015 SHALL have port o_frame_err, output, 1 bit: one-cycle strobe for a short frame.

Function
REQ-016 SHALL implement two states, IDLE and RUN; a sample with i_vld&i_new_fft moves IDLE->RUN as bin 0, and IDLE discards other samples.
REQ-017 SHALL keep a bin counter that advances only on i_vld; i_vld=0 cycles are bubbles with no state change.
REQ-018 SHALL compute power in a 2-stage pipeline (register the squares, then register the sum), so o_pwr_vld/o_pwr follow the accepted sample by exactly 2 cycles.
REQ-019 SHALL compute power at full precision with no truncation; (-2^(IN_W-1))^2*2 SHALL fit PWR_W unsigned.
REQ-020 SHALL track the peak with a strict greater-than compare, so ties keep the lowest bin index and bin 0 always seeds the peak.
REQ-021 SHALL accumulate energy as the sum of all FFT_LEN powers in EN_W bits, which cannot overflow.
REQ-022 SHALL OR i_clip_strb into a frame clip flag from the bin-0 cycle through the last-bin cycle.
REQ-023 SHALL, after bin FFT_LEN-1, pulse o_res_vld 3 cycles after that bin is accepted (1 cycle after its o_pwr_vld) and update o_peak_bin/o_peak_pwr/o_energy/o_clipped in the same cycle.
REQ-024 SHALL hold result outputs until the next o_res_vld.
REQ-025 SHALL, after the last bin, stay in RUN expecting i_new_fft; if a valid sample arrives without i_new_fft, it SHALL pulse o_frame_err, discard the sample and go to IDLE.
REQ-026 SHALL, when i_new_fft arrives with bin count !=0 and != FFT_LEN, pulse o_frame_err, drop the partial frame with no o_res_vld, and start a new frame at bin 0 with that sample.
REQ-027 SHALL keep per-bin o_pwr streaming for all accepted samples, including those of aborted frames.
REQ-028 SHALL allow back-to-back frames with no bubble between the last bin and the next bin 0.

Reset
REQ-029 SHALL, on i_init, put the FSM in IDLE, counters, accumulators and pipeline valids at 0, and all outputs at 0 on the next cycle.
REQ-030 SHALL, on i_init mid-frame, discard the frame, produce no o_res_vld and no o_frame_err, and drop the in-flight o_pwr_vld.

Structure
REQ-031 SHALL place no types in a package; widths are derived localparams.
REQ-032 SHALL use one sub-module, cplx_pwr (pipelined I^2+Q^2), instantiated once.

Verification (FFT_LEN=8, IN_W=4)
REQ-033 SHALL test a frame with bin5=(7,0) and other bins 0: o_peak_bin=5, o_peak_pwr=49, o_energy=49, and o_res_vld exactly 3 cycles after bin 7.
REQ-034 SHALL test a tie with bins 2 and 6 = (3,-4): o_pwr=25 for both, and o_peak_bin=2.
REQ-035 SHALL test all bins = (-8,-8): o_pwr=128 per bin, o_energy=1024, o_peak_bin=0.
REQ-036 SHALL test i_new_fft after 5 bins: o_frame_err=1 for one cycle, no o_res_vld, and the following full frame reported correctly.
REQ-037 SHALL test the REQ-033 frame with bubbles (i_vld=0 every other cycle): identical results, and i_clip_strb=1 at bin 3 gives o_clipped=1.
REQ-038 SHALL test i_init asserted at bin 4: all outputs 0, no o_res_vld, and the next frame accepted normally.
